shift_arbiter: RTL and testbench
================================

# shift_arbiter

Round-robin arbiter and two-stage pipeline sequencer that shares one 64-bit barrel shifter between NREQ requesters. Each requester presents an operand, shift amount and operation over valid/ready; the block grants one request per cycle, drives the shared shifter and returns the tagged result over a single valid/ready response port. It sits between the ALU issue ports and the log-stage barrel shifter datapath.

## Interface

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 64, datapath width (power of two).
- SHW, $clog2(W), shift-amount width.
- IDW, $clog2(NREQ), response tag width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_data  input  NREQ x W  operands.
- req_shamt  input  NREQ x SHW  shift amounts.
- req_op  input  NREQ x 2  operation, shift_op_e.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  W  shifted result.
- rsp_id  output  IDW  index of the originating requester.
- busy  output  1  any pipeline stage occupied.

## Operation

- Ops: SLL=00 (zero fill), SRL=01 (zero fill), SRA=10 (fill with operand bit W-1), ROR=11 (rotate right). shamt 0 returns the operand unchanged for all ops.
- Arbitration: round-robin pointer rr_ptr. grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ. req_ready[i] = grant[i] & s1_can_load.
- rr_ptr updates only on an accept (req_valid[k] & req_ready[k]): rr_ptr <= (k+1) mod NREQ. No accept: hold.
- Stage 1 (issue reg): holds data, shamt, op, id, s1_valid. Loads on accept.
- Stage 2 (output reg): rsp_data <= shift_core(s1 fields), rsp_id <= s1 id; s2_valid drives rsp_valid.
- Flow control: s2_can_load = !s2_valid | rsp_ready; s1_can_load = !s1_valid | s2_can_load. Stage 2 loads when s1_valid & s2_can_load; s1_valid clears on transfer unless reloaded in the same cycle.
- Outputs hold stable while rsp_valid & !rsp_ready.
- busy = s1_valid | s2_valid.

## Timing

- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, busy=0; req_ready combinationally 0 while in reset. In-flight operations are discarded. No output glitches after deassertion; first accept is possible in the first cycle with rst_n high.
- Latency: accept in cycle t gives rsp_valid in cycle t+2 if rsp_ready was high.
- Throughput: one op per cycle sustained with rsp_ready held high.
- Stall: rsp_ready low with both stages full forces all req_ready low the same cycle. On rsp_ready returning high, drain and accept resume in that cycle with no bubble.
- Simultaneous response drain and new accept in the same cycle is legal at both stages.
- req_ready depends combinationally on req_valid and rsp_ready. No combinational path from req_* to rsp_*.

## Structure

- Package shift_pkg: shift_op_e enum (SLL, SRL, SRA, ROR), W and SHW constants, and a packed struct shift_req_t {data, shamt, op, id} used by both pipeline registers.
- Sub-module shift_core: purely combinational W-bit shifter, SHW log stages with stage k shifting by 2^k under shamt[k], op-selected fill and rotate.
- shift_arbiter contains the round-robin arbiter, the two pipeline registers and the flow control.

## Test plan

- Single op: req 0 SRA, data 0x8000_0000_0000_0000, shamt 4 -> rsp_data 0xF800_0000_0000_0000, rsp_id 0, rsp_valid at accept+2.
- Op sweep: data 0x0123_4567_89AB_CDEF, shamt 8 -> SLL 0x2345_6789_ABCD_EF00, SRL 0x0001_2345_6789_ABCD, ROR 0xEF01_2345_6789_ABCD. shamt 0 returns the operand unchanged for every op.
- Fairness: all 4 requesters valid continuously from reset -> accept order 0,1,2,3,0,... and rsp_id in the same order.
- Backpressure: rsp_ready low for 5 cycles with a continuous stream -> exactly 2 ops accepted, then req_ready all 0. On rsp_ready high, results arrive in order with no loss or duplication.
- Boundary: SRA of 0xFFFF_FFFF_FFFF_FFFE with shamt 63 -> 0xFFFF_FFFF_FFFF_FFFF. SRL of the same with shamt 63 -> 0x1.
- Reset mid-stream: assert rst_n low with both stages full -> rsp_valid and busy drop immediately, rr_ptr=0. After release, requester 0 wins first if it is valid.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shared barrel-shifter arbiter.
package shift_pkg;

  localparam int unsigned W    = 64;
  localparam int unsigned SHW  = $clog2(W);
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = $clog2(NREQ);

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [SHW-1:0] shamt;
    shift_op_e      op;
    logic [IDW-1:0] id;
  } shift_req_t;

endpackage

// File: rtl/shift_core.sv
// Combinational log-stage barrel shifter: stage k shifts by 2^k when shamt[k] is set.
module shift_core #(
  parameter int unsigned W   = shift_pkg::W,
  parameter int unsigned SHW = $clog2(W)
) (
  input  logic [W-1:0]       data,
  input  logic [SHW-1:0]     shamt,
  input  shift_pkg::shift_op_e op,
  output logic [W-1:0]       result_c
);
  import shift_pkg::*;

  logic [SHW:0][W-1:0] st;

  assign st[0] = data;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned S = 2 ** k;
    logic [W-1:0] sh;

    // SRA fill always comes from the original operand's MSB
    always_comb begin
      sh = st[k];
      unique case (op)
        SLL:     sh = {st[k][W-1-S:0], {S{1'b0}}};
        SRL:     sh = {{S{1'b0}}, st[k][W-1:S]};
        SRA:     sh = {{S{data[W-1]}}, st[k][W-1:S]};
        default: sh = {st[k][S-1:0], st[k][W-1:S]};
      endcase
    end

    assign st[k+1] = shamt[k] ? sh : st[k];
  end

  assign result_c = st[SHW];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter and two-stage pipeline sharing one barrel shifter
// between NREQ requesters, returning tagged results on one valid/ready port.
module shift_arbiter #(
  parameter int unsigned NREQ = shift_pkg::NREQ,
  parameter int unsigned W    = shift_pkg::W,
  parameter int unsigned SHW  = $clog2(W),
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][W-1:0]    req_data,
  input  logic [NREQ-1:0][SHW-1:0]  req_shamt,
  input  logic [NREQ-1:0][1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [W-1:0]              rsp_data,
  output logic [IDW-1:0]            rsp_id,
  output logic                      busy
);
  import shift_pkg::*;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           any_grant;
  logic           accept;
  shift_req_t     s1_q;
  logic           s1_valid;
  logic           s1_valid_d;
  logic           s2_valid_d;
  logic           s1_can_load;
  logic           s2_can_load;
  logic           s2_load;
  logic [W-1:0]   core_result;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!any_grant && req_valid[idx]) begin
        any_grant = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign s2_can_load = !rsp_valid || rsp_ready;
  assign s1_can_load = !s1_valid || s2_can_load;
  assign s2_load     = s1_valid && s2_can_load;
  assign accept      = rst_n && any_grant && s1_can_load;

  assign s1_valid_d  = accept || (s1_valid && !s2_load);
  assign s2_valid_d  = s2_can_load ? s1_valid : rsp_valid;

  // Ready is forced low while reset is asserted
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  shift_core #(
    .W   (W),
    .SHW (SHW)
  ) u_core (
    .data     (s1_q.data),
    .shamt    (s1_q.shamt),
    .op       (s1_q.op),
    .result_c (core_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      s1_q      <= '0;
      s1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        s1_q   <= '{data:  req_data[grant_idx],
                    shamt: req_shamt[grant_idx],
                    op:    shift_op_e'(req_op[grant_idx]),
                    id:    grant_idx};
      end
      if (s2_load) begin
        rsp_data <= core_result;
        rsp_id   <= IDW'(s1_q.id);
      end
      s1_valid  <= s1_valid_d;
      rsp_valid <= s2_valid_d;
      busy      <= s1_valid_d || s2_valid_d;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, scoreboard, and
// directed sequences for fairness, backpressure and mid-stream reset.
module tb_shift_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 64;
  localparam int unsigned SHW  = 6;
  localparam int unsigned IDW  = 2;
  localparam int unsigned NVEC = 13;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   data;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   exp;
  } vec_t;

  typedef struct {
    logic [W-1:0]   data;
    logic [IDW-1:0] id;
  } sb_t;

  logic                     clk;
  logic                     rst_n;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0][W-1:0]   req_data;
  logic [NREQ-1:0][SHW-1:0] req_shamt;
  logic [NREQ-1:0][1:0]     req_op;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [W-1:0]             rsp_data;
  logic [IDW-1:0]           rsp_id;
  logic                     busy;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  int n_acc    = 0;
  logic [NREQ-1:0] acc_vec = '0;
  sb_t  sb_q[$];
  int   acc_log[$];
  int   rsp_log[$];
  vec_t vecs[NVEC];

  shift_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .SHW  (SHW),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d, input int sh);
    logic [W-1:0] r;
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = W'($signed(d) >>> sh);
      default: r = (d >> sh) | (d << (W - sh));
    endcase
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on response transfer
  always @(negedge clk) begin
    sb_t e;
    acc_vec = '0;
    if (rst_n) begin
      chk("ready_onehot", ($countones(req_ready) <= 1), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.data = model(req_op[i], req_data[i], int'(req_shamt[i]));
          e.id   = IDW'(i);
          sb_q.push_back(e);
          acc_log.push_back(i);
          acc_vec[i] = 1'b1;
          n_acc++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_log.push_back(int'(rsp_id));
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", rsp_data, e.data);
          chk("sb_id", rsp_id, e.id);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload(input int i);
    req_data[i]  = {$urandom, $urandom};
    req_shamt[i] = SHW'($urandom);
    req_op[i]    = 2'($urandom);
  endtask

  // Each cycle, give a fresh operand to whichever requester was just accepted
  task automatic run_stream(input int n);
    repeat (n) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (acc_vec[i]) rand_payload(i);
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 50) begin
      tick();
      c++;
    end
    chk("idle", busy, 0);
  endtask

  task automatic do_single(input int k);
    bit accepted = 0;
    bit got = 0;
    int acc_c = 0;
    req_op[0]    = vecs[k].op;
    req_data[0]  = vecs[k].data;
    req_shamt[0] = vecs[k].shamt;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        accepted = 1;
        acc_c = cyc;
      end
    end
    chk($sformatf("vec%0d_accept", k), accepted, 1);
    tick();
    req_valid[0] = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        chk($sformatf("vec%0d_data", k), rsp_data, vecs[k].exp);
        chk($sformatf("vec%0d_id", k), rsp_id, 0);
        chk($sformatf("vec%0d_latency", k), cyc - acc_c, 2);
      end
    end
    chk($sformatf("vec%0d_rsp", k), got, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] hold_d;
    int n0;

    vecs[0]  = '{2'b10, 64'h8000_0000_0000_0000, 6'd4,  64'hF800_0000_0000_0000};
    vecs[1]  = '{2'b00, 64'h0123_4567_89AB_CDEF, 6'd8,  64'h2345_6789_ABCD_EF00};
    vecs[2]  = '{2'b01, 64'h0123_4567_89AB_CDEF, 6'd8,  64'h0001_2345_6789_ABCD};
    vecs[3]  = '{2'b11, 64'h0123_4567_89AB_CDEF, 6'd8,  64'hEF01_2345_6789_ABCD};
    vecs[4]  = '{2'b10, 64'h0123_4567_89AB_CDEF, 6'd8,  64'h0001_2345_6789_ABCD};
    vecs[5]  = '{2'b00, 64'hFEDC_BA98_7654_3210, 6'd0,  64'hFEDC_BA98_7654_3210};
    vecs[6]  = '{2'b01, 64'hFEDC_BA98_7654_3210, 6'd0,  64'hFEDC_BA98_7654_3210};
    vecs[7]  = '{2'b10, 64'hFEDC_BA98_7654_3210, 6'd0,  64'hFEDC_BA98_7654_3210};
    vecs[8]  = '{2'b11, 64'hFEDC_BA98_7654_3210, 6'd0,  64'hFEDC_BA98_7654_3210};
    vecs[9]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 6'd63, 64'h0000_0000_0000_0001};
    vecs[11] = '{2'b00, 64'h0000_0000_0000_0001, 6'd63, 64'h8000_0000_0000_0000};
    vecs[12] = '{2'b11, 64'h0000_0000_0000_0001, 6'd1,  64'h8000_0000_0000_0000};

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_shamt = '0;
    req_op    = '0;
    tick();
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < NVEC; k++) do_single(k);
    wait_idle();

    // Fairness from reset with all requesters continuously valid
    rst_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < NREQ; i++) rand_payload(i);
    req_valid = '1;
    tick();
    acc_log.delete();
    rsp_log.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("fair_first_grant", req_ready, 4'b0001);
    run_stream(11);
    req_valid = '0;
    wait_idle();
    chk("fair_count", (acc_log.size() >= 8), 1);
    for (int k = 0; k < 8 && k < acc_log.size() && k < rsp_log.size(); k++) begin
      chk($sformatf("fair_acc%0d", k), acc_log[k], k % NREQ);
      chk($sformatf("fair_rsp%0d", k), rsp_log[k], k % NREQ);
    end

    // Backpressure: only two ops fit while the consumer stalls
    rsp_ready = 1'b0;
    n0 = n_acc;
    req_valid = '1;
    run_stream(5);
    chk("bp_accepts", n_acc - n0, 2);
    chk("bp_ready", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    hold_d = rsp_data;
    run_stream(1);
    chk("bp_hold", rsp_data, hold_d);
    chk("bp_ready2", req_ready, 0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_resume", (req_ready != 0), 1);
    run_stream(4);
    req_valid = '0;
    wait_idle();
    chk("bp_sb_empty", sb_q.size(), 0);

    // Reset with both stages full discards in-flight work
    rsp_ready = 1'b0;
    req_valid = '1;
    run_stream(4);
    chk("mid_busy", busy, 1);
    chk("mid_rsp_valid", rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_data", rsp_data, 0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_idle();
    chk("mid_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
